muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide controller that owns the HI/LO result path for MULT, MULTU, DIV and DIVU. It accepts an operation from the EX stage and runs a radix-2 shift-add (multiply) or restoring (divide) iteration over WIDTH cycles. It then applies sign correction and issues a one-cycle HI/LO write strobe. While running it drives Busy, which the hazard logic uses to stall MFHI/MFLO and any new mul/div op in EX.

---
 rtl/muldiv_sequencer_pkg.sv | 32 +++
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - op_e    : operation encoding as presented on Op (MULT, MULTU, DIV, DIVU)
//   - state_e : sequencer FSM states
//   - helpers : decode of divide / signed operations
package muldiv_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // MULT and DIV are the signed flavours (even encodings).
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> mul/div sequencer bundle.
//   master (EX / hazard side): drives Start, Op, A, B, Abort;
//                              observes Busy, Done, HiLoWrite, HiOut, LoOut
//   slave  (sequencer)       : the mirror image
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             Start;
    op_e              Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Abort;
    logic             Busy;
    logic             Done;
    logic             HiLoWrite;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;

    modport master (
        output Start, Op, A, B, Abort,
        input  Busy, Done, HiLoWrite, HiOut, LoOut
    );

    modport slave (
        input  Start, Op, A, B, Abort,
        output Busy, Done, HiLoWrite, HiOut, LoOut
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the mul/div datapath (purely combinational).
//   op_is_div : 0 = shift-add multiply, 1 = restoring divide
//   acc_in    : multiply: {partial product high, multiplier remaining}
//               divide  : {remainder, dividend bits remaining / quotient so far}
//   operand   : multiplicand (multiply) or divisor (divide), magnitude form
//   acc_out   : accumulator after the step; for divide, bit 0 is the new
//               quotient bit
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 op_is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       shifted_rem;
    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   div_next;

    // Multiply: the add is one bit wider so its carry shifts into the top
    // of the accumulator instead of being lost.
    assign add_sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    assign mul_next = acc_in[0] ? {add_sum, acc_in[WIDTH-1:1]}
                                : {1'b0, acc_in[2*WIDTH-1:1]};

    // Divide: the remainder is always below the divisor, so after shifting in
    // the next dividend bit it fits WIDTH+1 bits, and the trial difference's
    // MSB is a reliable "went negative" flag.
    assign shifted_rem = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    assign trial       = shifted_rem - {1'b0, operand};
    assign q_bit       = ~trial[WIDTH];
    assign rem_next    = q_bit ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
    assign div_next    = {rem_next, acc_in[WIDTH-2:0], q_bit};

    assign acc_out = op_is_div ? div_next : mul_next;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning the HI/LO result path.
//   Clk : clock, rising edge
//   Rst : asynchronous active-low reset
//   bus : slave side of muldiv_sequencer_if
//         Start/Op/A/B sampled in IDLE; Abort cancels an op in CALC/SIGN;
//         Busy (state != IDLE), Done/HiLoWrite (one-cycle write strobe) and
//         HiOut/LoOut are all registered.
// Timeline: start edge -> WIDTH CALC edges -> SIGN edge loads HiOut/LoOut ->
// DONE cycle with the strobe. Divide by zero skips CALC entirely.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    op_e                op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               rsign_q, rsign_d;
    logic               remsign_q, remsign_d;
    logic               div0_q, div0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Start-time decode and operand magnitudes.
    logic               start_div;
    logic               start_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    assign start_div    = op_is_div(bus.Op);
    assign start_signed = op_is_signed(bus.Op);
    assign a_abs = (start_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs = (start_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Sign-corrected results, consumed on the SIGN edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = rsign_q   ? -acc_q               : acc_q;
    assign quot_fix = rsign_q   ? -acc_q[WIDTH-1:0]     : acc_q[WIDTH-1:0];
    assign rem_fix  = remsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    logic [2*WIDTH-1:0] step_acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_is_div (op_is_div(op_q)),
        .acc_in    (acc_q),
        .operand   (operand_q),
        .acc_out   (step_acc)
    );

    always_comb begin
        // NOTE: every _d starts as a hold of its _q so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        rsign_d   = rsign_q;
        remsign_d = remsign_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Abort) begin
                    op_d      = bus.Op;
                    count_d   = '0;
                    rsign_d   = start_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    remsign_d = start_signed & start_div & bus.A[WIDTH-1];
                    busy_d    = 1'b1;
                    if (start_div && bus.B == '0) begin
                        // Raw A is parked in the low half so HiOut gets it unmodified.
                        div0_d    = 1'b1;
                        acc_d     = {{WIDTH{1'b0}}, bus.A};
                        operand_d = '0;
                        state_d   = SIGN;
                    end else begin
                        div0_d    = 1'b0;
                        acc_d     = {{WIDTH{1'b0}}, (start_div ? a_abs : b_abs)};
                        operand_d = start_div ? b_abs : a_abs;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_d = SIGN;
                end
            end
            SIGN: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (div0_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = '1;
                    end else if (op_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The write was committed on the SIGN edge; Abort cannot undo it.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            operand_q <= '0;
            rsign_q   <= 1'b0;
            remsign_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            rsign_q   <= rsign_d;
            remsign_q <= remsign_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.HiLoWrite = done_q;
    assign bus.HiOut     = hi_q;
    assign bus.LoOut     = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int WIDTH = 32;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start one op, wait (bounded) for Done, then check latency, strobe and
    // results. exp_lat counts edges after the start edge until Done is seen.
    // With noise set, a stray Start is pulsed mid-CALC and must be ignored.
    task automatic run_op(input string tag, input op_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit noise);
        int lat;
        bit busy_ok;
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (bus.Done !== 1'b1 && lat < 60) begin
            if (bus.Busy !== 1'b1) busy_ok = 1'b0;
            if (noise && lat == 5) begin
                bus.Start = 1'b1;
                bus.Op    = OP_MULTU;
                bus.A     = '1;
                bus.B     = '1;
            end else begin
                bus.Start = 1'b0;
            end
            step();
            lat++;
        end
        bus.Start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, bus.Busy}, 64'd1);
        check({tag, "_hilowrite"}, {63'd0, bus.HiLoWrite}, 64'd1);
        check({tag, "_hi"}, {32'd0, bus.HiOut}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, bus.LoOut}, {32'd0, exp_lo});
        step();
        check({tag, "_done_single"}, {63'd0, bus.Done}, 64'd0);
        check({tag, "_busy_after"}, {63'd0, bus.Busy}, 64'd0);
    endtask

    initial begin
        bit seen_done;

        Rst       = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        bus.Abort = 1'b0;

        #2;
        check("rst_busy", {63'd0, bus.Busy}, 64'd0);
        check("rst_done", {63'd0, bus.Done}, 64'd0);
        check("rst_hilowrite", {63'd0, bus.HiLoWrite}, 64'd0);
        check("rst_hi", {32'd0, bus.HiOut}, 64'd0);
        check("rst_lo", {32'd0, bus.LoOut}, 64'd0);

        #20 Rst = 1'b1;
        step();

        // -3 * 7 = -21
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        // -7 / 2 = -3 rem -1
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // 100 / 7 = 14 rem 2, with an ignored Start mid-CALC
        run_op("divu_noise", OP_DIVU, 32'd100, 32'd7, 33,
               32'd2, 32'd14, 1'b1);
        // Divide by zero: short path, LO all ones, HI raw A
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1,
               32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        // Most-negative / -1 wraps to most-negative, remainder 0
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
               32'h0000_0000, 32'h8000_0000, 1'b0);

        // Start together with Abort in IDLE: nothing starts.
        bus.Start = 1'b1;
        bus.Abort = 1'b1;
        bus.Op    = OP_MULT;
        bus.A     = 32'd2;
        bus.B     = 32'd3;
        step();
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        check("abort_idle_busy", {63'd0, bus.Busy}, 64'd0);
        step();
        check("abort_idle_done", {63'd0, bus.Done}, 64'd0);
        check("abort_idle_lo", {32'd0, bus.LoOut}, 64'h8000_0000);

        run_op("mult_5x6", OP_MULT, 32'd5, 32'd6, 33, 32'd0, 32'd30, 1'b0);

        // DIV 9/3 aborted while count == 10; stray Start pulses ignored.
        bus.Start = 1'b1;
        bus.Op    = OP_DIV;
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.Start = (i == 3);
            step();
        end
        bus.Start = 1'b0;
        check("abort_calc_busy_before", {63'd0, bus.Busy}, 64'd1);
        bus.Abort = 1'b1;
        step();
        bus.Abort = 1'b0;
        check("abort_calc_busy_after", {63'd0, bus.Busy}, 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done !== 1'b0 || bus.HiLoWrite !== 1'b0) seen_done = 1'b1;
            step();
        end
        check("abort_calc_no_done", {63'd0, seen_done}, 64'd0);
        check("abort_calc_hi", {32'd0, bus.HiOut}, 64'd0);
        check("abort_calc_lo", {32'd0, bus.LoOut}, 64'd30);

        // Asynchronous reset between edges in the middle of CALC.
        bus.Start = 1'b1;
        bus.Op    = OP_MULTU;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        step();
        bus.Start = 1'b0;
        repeat (5) step();
        #2 Rst = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.Busy}, 64'd0);
        check("arst_done", {63'd0, bus.Done}, 64'd0);
        check("arst_hi", {32'd0, bus.HiOut}, 64'd0);
        check("arst_lo", {32'd0, bus.LoOut}, 64'd0);
        #10 Rst = 1'b1;
        step();
        check("arst_idle", {63'd0, bus.Busy}, 64'd0);

        // -1 * most-negative = +2^31
        run_op("mult_post_rst", OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 33,
               32'h0000_0000, 32'h8000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
